// File: rtl/rom_uploader.sv
// UART-fed program loader: receives a C8/len/data/checksum frame and writes each data byte into CPU memory.
// Latency: each write strobe comes two clk cycles after the stop-bit sample; done/error follow the checksum byte by two cycles.
// Backpressure: none; the memory port must accept one write per received byte, and a silent line mid-frame aborts on timeout.
module rom_uploader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [11:0] BASE_ADDR    = 12'h200,
  parameter int          TIMEOUT_CLKS = 10_000_000
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rx,
  output logic        uploading,
  output logic        upload_en,
  output logic [11:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] HALF_M1 = 32'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] BIT_M1  = 32'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CLKS);
  localparam logic [7:0]  SYNC    = 8'hC8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM} fr_state_t;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t   rx_state_q, rx_state_d;
  logic [31:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frm_err_q, frm_err_d;

  fr_state_t   state_q, state_d;
  logic [3:0]  len_hi_q, len_hi_d;
  logic [11:0] len_full;
  logic [11:0] addr_q, addr_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        upload_en_q, upload_en_d;
  logic [11:0] upload_addr_q, upload_addr_d;
  logic [7:0]  upload_data_q, upload_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection (idle line is high).
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rx_state_q <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_valid_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_valid_q <= rx_valid_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Receiver next state: recheck start at mid-bit, then sample data and stop bits one bit-time apart.
  always_comb begin
    rx_state_d = rx_state_q;
    baud_d     = baud_q + 32'd1;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (baud_q == HALF_M1) begin
          baud_d     = '0;
          // A start bit that has gone high again by mid-bit was only a glitch.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_q == BIT_M1) begin
          baud_d  = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (baud_q == BIT_M1) begin
          baud_d     = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rx_sync_q;
          frm_err_d  = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame state register and output registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= S_IDLE;
      len_hi_q      <= '0;
      addr_q        <= BASE_ADDR;
      cnt_q         <= '0;
      csum_q        <= '0;
      tmo_q         <= '0;
      upload_en_q   <= 1'b0;
      upload_addr_q <= BASE_ADDR;
      upload_data_q <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_hi_q      <= len_hi_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      csum_q        <= csum_d;
      tmo_q         <= tmo_d;
      upload_en_q   <= upload_en_d;
      upload_addr_q <= upload_addr_d;
      upload_data_q <= upload_data_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign len_full = {len_hi_q, shift_q};

  // Frame next state: abort conditions take priority over byte handling.
  always_comb begin
    state_d       = state_q;
    len_hi_d      = len_hi_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    csum_d        = csum_q;
    tmo_d         = (state_q == S_IDLE) ? 32'd0 : tmo_q + 32'd1;
    upload_en_d   = 1'b0;
    upload_addr_d = upload_addr_q;
    upload_data_d = upload_data_q;
    done_d        = done_q;
    error_d       = error_q;
    if (state_q != S_IDLE && (frm_err_q || tmo_q >= TMO_LIM)) begin
      state_d = S_IDLE;
      error_d = 1'b1;
      done_d  = 1'b0;
    end else if (rx_valid_q) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (shift_q == SYNC) begin
            state_d = S_LEN_HI;
            done_d  = 1'b0;
            error_d = 1'b0;
            csum_d  = '0;
            cnt_d   = '0;
          end
        end
        S_LEN_HI: begin
          len_hi_d = shift_q[3:0];
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (len_full > 12'hE00) begin
            state_d = S_IDLE;
            error_d = 1'b1;
          end else if (len_full == 12'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
            addr_d  = BASE_ADDR;
            cnt_d   = len_full;
          end
        end
        S_DATA: begin
          upload_en_d   = 1'b1;
          upload_addr_d = addr_q;
          upload_data_d = shift_q;
          addr_d        = addr_q + 12'd1;
          csum_d        = csum_q + shift_q;
          cnt_d         = cnt_q - 12'd1;
          if (cnt_q == 12'd1) state_d = S_CSUM;
        end
        S_CSUM: begin
          state_d = S_IDLE;
          if (shift_q == csum_q) done_d  = 1'b1;
          else                   error_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign uploading   = (state_q != S_IDLE);
  assign upload_en   = upload_en_q;
  assign upload_addr = upload_addr_q;
  assign upload_data = upload_data_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_rom_uploader.sv
module tb_rom_uploader;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic        clk;
  logic        res;
  logic        rx;
  logic        uploading;
  logic        upload_en;
  logic [11:0] upload_addr;
  logic [7:0]  upload_data;
  logic        done;
  logic        error;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rom_uploader #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (12'h200),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk        (clk),
    .res        (res),
    .rx         (rx),
    .uploading  (uploading),
    .upload_en  (upload_en),
    .upload_addr(upload_addr),
    .upload_data(upload_data),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (res === 1'b1 && upload_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed=%h/%h expected=none", upload_addr, upload_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        assert ({upload_addr, upload_data} === {e.a, e.d}) else begin
          errors++;
          $error("FAIL write observed=%h/%h expected=%h/%h", upload_addr, upload_data, e.a, e.d);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    idle(CPB);
    rx = 1'b1;
    idle(4);
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    idle(4);
    @(negedge clk);
  endtask

  initial begin
    res = 1'b0;
    rx  = 1'b1;
    idle(5);
    @(negedge clk);
    chk("rst_uploading", uploading, 0);
    chk("rst_en", upload_en, 0);
    chk("rst_addr", upload_addr, 12'h200);
    chk("rst_data", upload_data, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    res = 1'b1;
    idle(10);

    // Good three-byte frame.
    send_byte(8'hC8, 0);
    settle();
    chk("f1_uploading_after_sync", uploading, 1);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    expect_wr(12'h200, 8'h11); send_byte(8'h11, 0);
    expect_wr(12'h201, 8'h22); send_byte(8'h22, 0);
    expect_wr(12'h202, 8'h33); send_byte(8'h33, 0);
    send_byte(8'h66, 0);
    settle();
    chk("f1_done", done, 1);
    chk("f1_error", error, 0);
    chk("f1_uploading", uploading, 0);
    chk("f1_q_empty", exp_q.size(), 0);
    chk("f1_addr_hold", upload_addr, 12'h202);
    chk("f1_data_hold", upload_data, 8'h33);

    // Bad checksum: writes stay, error raised.
    send_byte(8'hC8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    expect_wr(12'h200, 8'hAA); send_byte(8'hAA, 0);
    expect_wr(12'h201, 8'h55); send_byte(8'h55, 0);
    send_byte(8'h00, 0);
    settle();
    chk("f2_error", error, 1);
    chk("f2_done", done, 0);
    chk("f2_uploading", uploading, 0);
    chk("f2_q_empty", exp_q.size(), 0);

    // Short start-bit glitch must be discarded before the next frame.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CPB);

    // Empty frame.
    send_byte(8'hC8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    settle();
    chk("f3_done", done, 1);
    chk("f3_error", error, 0);
    chk("f3_uploading", uploading, 0);

    // Oversize length aborts right after the length bytes.
    send_byte(8'hC8, 0);
    send_byte(8'h0E, 0);
    send_byte(8'h01, 0);
    settle();
    chk("f4_error", error, 1);
    chk("f4_done", done, 0);
    chk("f4_uploading", uploading, 0);

    // Non-sync bytes in idle are ignored; framing error mid-frame aborts.
    send_byte(8'h41, 0);
    send_byte(8'h7F, 0);
    settle();
    chk("f5_idle_uploading", uploading, 0);
    chk("f5_idle_error_held", error, 1);
    send_byte(8'hC8, 0);
    settle();
    chk("f5_sync_uploading", uploading, 1);
    chk("f5_sync_clears_error", error, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 1);
    settle();
    chk("f5_error", error, 1);
    chk("f5_done", done, 0);
    chk("f5_uploading", uploading, 0);

    // Timeout after one write.
    send_byte(8'hC8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    expect_wr(12'h200, 8'h10); send_byte(8'h10, 0);
    settle();
    chk("f6_uploading_pre_tmo", uploading, 1);
    chk("f6_error_pre_tmo", error, 0);
    idle(TMO + 50);
    @(negedge clk);
    chk("f6_error", error, 1);
    chk("f6_done", done, 0);
    chk("f6_uploading", uploading, 0);
    chk("f6_q_empty", exp_q.size(), 0);

    // Reset mid-frame after one write, then a fresh frame.
    send_byte(8'hC8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    expect_wr(12'h200, 8'hAB); send_byte(8'hAB, 0);
    settle();
    chk("f7_uploading_pre_rst", uploading, 1);
    res = 1'b0;
    idle(3);
    @(negedge clk);
    chk("f7_rst_uploading", uploading, 0);
    chk("f7_rst_en", upload_en, 0);
    chk("f7_rst_addr", upload_addr, 12'h200);
    chk("f7_rst_data", upload_data, 0);
    chk("f7_rst_done", done, 0);
    chk("f7_rst_error", error, 0);
    res = 1'b1;
    idle(5);
    send_byte(8'hC8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    expect_wr(12'h200, 8'h5A); send_byte(8'h5A, 0);
    send_byte(8'h5A, 0);
    settle();
    chk("f7_done", done, 1);
    chk("f7_error", error, 0);
    chk("f7_uploading", uploading, 0);
    chk("f7_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
